// File: rtl/uart_rx_deframer.sv
// UART receive front end: synchronises the serial line, recovers frames with
// 2-of-3 majority sampling and false-start rejection, and holds each payload
// with its error flags on a valid/ready register.
module uart_rx_deframer #(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY_MODE = 0,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned OVERSAMPLE  = 16
) (
   input  logic                 baud_clk,
   input  logic                 reset,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 overrun_err,
   output logic                 rx_active
);

   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W = 4;
   localparam int unsigned MID   = OVERSAMPLE / 2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
   localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
   localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(MID + 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BRKWAIT
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           sync_q, sync_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [1:0]           samp_q, samp_d;
   logic                 par_err_q, par_err_d;
   logic                 stop_err_q, stop_err_d;
   logic                 all_zero_q, all_zero_d;

   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 brk_q, brk_d;
   logic                 ovr_q, ovr_d;
   logic                 active_q, active_d;

   logic rxs;
   logic maj;
   logic decide;
   logic bit_end;
   logic complete;
   logic frame_brk;
   logic frame_ferr;

   assign rxs     = sync_q[1];
   assign maj     = (samp_q[0] & samp_q[1]) | (rxs & (samp_q[0] | samp_q[1]));
   assign decide  = (cnt_q == CNT_DEC);
   assign bit_end = (cnt_q == CNT_LAST);

   // State, datapath and output registers
   always_ff @(posedge baud_clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         sync_q     <= 2'b11;
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         samp_q     <= '0;
         par_err_q  <= 1'b0;
         stop_err_q <= 1'b0;
         all_zero_q <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         brk_q      <= 1'b0;
         ovr_q      <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         samp_q     <= samp_d;
         par_err_q  <= par_err_d;
         stop_err_q <= stop_err_d;
         all_zero_q <= all_zero_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         brk_q      <= brk_d;
         ovr_q      <= ovr_d;
         active_q   <= active_d;
      end
   end

   // Frame FSM, bit timer, majority sampling and holding-register update
   always_comb begin
      state_d    = state_q;
      sync_d     = {sync_q[0], rx_in};
      cnt_d      = bit_end ? '0 : cnt_q + CNT_W'(1);
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      samp_d     = samp_q;
      par_err_d  = par_err_q;
      stop_err_d = stop_err_q;
      all_zero_d = all_zero_q;
      complete   = 1'b0;
      frame_brk  = 1'b0;
      frame_ferr = 1'b0;
      data_d     = data_q;
      valid_d    = valid_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      brk_d      = brk_q;
      ovr_d      = ovr_q;

      if (cnt_q == CNT_S0) samp_d[0] = rxs;
      if (cnt_q == CNT_S1) samp_d[1] = rxs;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rxs) begin
               state_d    = START;
               bit_cnt_d  = '0;
               par_err_d  = 1'b0;
               stop_err_d = 1'b0;
               all_zero_d = 1'b1;
            end
         end
         START: begin
            if (decide && maj) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (bit_end) begin
               state_d = DATA;
               cnt_d   = '0;
            end
         end
         DATA: begin
            if (decide) begin
               shift_d = {maj, shift_q[DATA_BITS-1:1]};
               if (maj) all_zero_d = 1'b0;
            end
            if (bit_end) begin
               if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_d = '0;
                  cnt_d     = '0;
                  state_d   = (PARITY_MODE != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         PARITY: begin
            if (decide) begin
               par_err_d = (PARITY_MODE == 1) ? (maj != ^shift_q) : (maj == ^shift_q);
               if (maj) all_zero_d = 1'b0;
            end
            if (bit_end) begin
               state_d = STOP;
               cnt_d   = '0;
            end
         end
         STOP: begin
            if (decide) begin
               if (!maj) stop_err_d = 1'b1;
               else      all_zero_d = 1'b0;
               if (bit_cnt_q == STOP_LAST) begin
                  // Finish at mid-bit so an immediately following start edge is seen
                  complete   = 1'b1;
                  frame_brk  = all_zero_q & ~maj;
                  frame_ferr = stop_err_q | ~maj;
                  bit_cnt_d  = '0;
                  cnt_d      = '0;
                  state_d    = (!rxs && frame_brk) ? BRKWAIT : IDLE;
               end
            end else if (bit_end) begin
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
         end
         BRKWAIT: begin
            cnt_d = '0;
            if (rxs) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (complete) begin
         if (!valid_q || rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            perr_d  = par_err_q;
            ferr_d  = frame_ferr;
            brk_d   = frame_brk;
            ovr_d   = 1'b0;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && rx_ready) begin
         valid_d = 1'b0;
         perr_d  = 1'b0;
         ferr_d  = 1'b0;
         brk_d   = 1'b0;
         ovr_d   = 1'b0;
      end

      active_d = (state_d != IDLE);
   end

   assign rx_data     = data_q;
   assign rx_valid    = valid_q;
   assign parity_err  = perr_q;
   assign frame_err   = ferr_q;
   assign break_det   = brk_q;
   assign overrun_err = ovr_q;
   assign rx_active   = active_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: three configurations (8N1, 8E1, 7O2)
// driven with hand-built frames, checked against hand-computed words and flags.
module tb_uart_rx_deframer;

   localparam int unsigned OS = 16;

   typedef struct packed {
      logic [8:0] data;
      logic [3:0] flags;   // {parity, frame, break, overrun}
   } rec_t;

   logic baud_clk;
   logic reset;
   logic rx_a, rx_b, rx_c;
   logic ready_a, ready_b, ready_c;

   logic [7:0] data_a, data_b;
   logic [6:0] data_c;
   logic valid_a, valid_b, valid_c;
   logic pe_a, pe_b, pe_c;
   logic fe_a, fe_b, fe_c;
   logic bd_a, bd_b, bd_c;
   logic oe_a, oe_b, oe_c;
   logic act_a, act_b, act_c;

   rec_t q_a[$];
   rec_t q_b[$];
   rec_t q_c[$];

   int checks;
   int errors;

   uart_rx_deframer #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE(OS)) u_a (
      .baud_clk(baud_clk), .reset(reset), .rx_in(rx_a), .rx_data(data_a), .rx_valid(valid_a),
      .rx_ready(ready_a), .parity_err(pe_a), .frame_err(fe_a), .break_det(bd_a),
      .overrun_err(oe_a), .rx_active(act_a));

   uart_rx_deframer #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(OS)) u_b (
      .baud_clk(baud_clk), .reset(reset), .rx_in(rx_b), .rx_data(data_b), .rx_valid(valid_b),
      .rx_ready(ready_b), .parity_err(pe_b), .frame_err(fe_b), .break_det(bd_b),
      .overrun_err(oe_b), .rx_active(act_b));

   uart_rx_deframer #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .OVERSAMPLE(OS)) u_c (
      .baud_clk(baud_clk), .reset(reset), .rx_in(rx_c), .rx_data(data_c), .rx_valid(valid_c),
      .rx_ready(ready_c), .parity_err(pe_c), .frame_err(fe_c), .break_det(bd_c),
      .overrun_err(oe_c), .rx_active(act_c));

   initial baud_clk = 1'b0;
   always #5 baud_clk = ~baud_clk;

   // Record every accepted word on each instance
   always @(negedge baud_clk) begin
      if (!reset && valid_a && ready_a) q_a.push_back({1'b0, data_a, pe_a, fe_a, bd_a, oe_a});
      if (!reset && valid_b && ready_b) q_b.push_back({1'b0, data_b, pe_b, fe_b, bd_b, oe_b});
      if (!reset && valid_c && ready_c) q_c.push_back({2'b00, data_c, pe_c, fe_c, bd_c, oe_c});
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge baud_clk);
      #1;
   endtask

   task automatic set_rx(input int inst, input logic v);
      case (inst)
         0:       rx_a = v;
         1:       rx_b = v;
         default: rx_c = v;
      endcase
   endtask

   // Drive bits[0..n-1] onto the chosen line, one bit period each
   task automatic send_bits(input int inst, input logic [15:0] bits, input int n);
      logic [15:0] b;
      b = bits;
      for (int i = 0; i < n; i++) begin
         set_rx(inst, b[i]);
         repeat (OS) tick();
      end
   endtask

   task automatic pop_rec(input int inst, output rec_t r);
      r = '1;
      case (inst)
         0:       if (q_a.size() > 0) r = q_a.pop_front();
         1:       if (q_b.size() > 0) r = q_b.pop_front();
         default: if (q_c.size() > 0) r = q_c.pop_front();
      endcase
   endtask

   initial begin
      rec_t r;
      logic seen;
      checks  = 0;
      errors  = 0;
      reset   = 1'b1;
      rx_a    = 1'b1;
      rx_b    = 1'b1;
      rx_c    = 1'b1;
      ready_a = 1'b1;
      ready_b = 1'b1;
      ready_c = 1'b0;

      repeat (3) tick();
      @(negedge baud_clk);
      check_eq("reset_a_outputs", {24'h0, data_a},
               32'h0);
      check_eq("reset_a_flags", {25'h0, valid_a, pe_a, fe_a, bd_a, oe_a, act_a, 1'b0}, 32'h0);
      tick();
      reset = 1'b0;
      repeat (4) tick();

      // 8N1 back-to-back 0x55, 0xA3
      send_bits(0, {6'h3F, 1'b1, 8'h55, 1'b0}, 10);
      send_bits(0, {6'h3F, 1'b1, 8'hA3, 1'b0}, 10);
      rx_a = 1'b1;
      repeat (2 * OS) tick();
      @(negedge baud_clk);
      check_eq("b2b_count", q_a.size(), 2);
      pop_rec(0, r);
      check_eq("b2b_data0", r.data, 9'h055);
      check_eq("b2b_flags0", r.flags, 4'h0);
      pop_rec(0, r);
      check_eq("b2b_data1", r.data, 9'h0A3);
      check_eq("b2b_flags1", r.flags, 4'h0);

      // Even parity: 0x07 has odd weight, so parity bit 1 is correct
      send_bits(1, {5'h1F, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
      send_bits(1, {5'h1F, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
      rx_b = 1'b1;
      repeat (2 * OS) tick();
      @(negedge baud_clk);
      check_eq("par_count", q_b.size(), 2);
      pop_rec(1, r);
      check_eq("par_bad_data", r.data, 9'h007);
      check_eq("par_bad_flags", r.flags, 4'b1000);
      pop_rec(1, r);
      check_eq("par_good_data", r.data, 9'h007);
      check_eq("par_good_flags", r.flags, 4'b0000);

      // False start: 4-cycle glitch
      seen = 1'b0;
      rx_a = 1'b0;
      for (int i = 0; i < 4 + 3 * OS; i++) begin
         if (i == 4) rx_a = 1'b1;
         @(negedge baud_clk);
         seen = seen | act_a;
         tick();
      end
      @(negedge baud_clk);
      check_eq("glitch_active_seen", seen, 1'b1);
      check_eq("glitch_no_word", q_a.size(), 0);
      check_eq("glitch_valid", valid_a, 1'b0);
      check_eq("glitch_idle", act_a, 1'b0);

      // Overrun: three frames with consumer stalled
      ready_a = 1'b0;
      tick();
      send_bits(0, {6'h3F, 1'b1, 8'h11, 1'b0}, 10);
      send_bits(0, {6'h3F, 1'b1, 8'h22, 1'b0}, 10);
      send_bits(0, {6'h3F, 1'b1, 8'h33, 1'b0}, 10);
      rx_a = 1'b1;
      repeat (2 * OS) tick();
      @(negedge baud_clk);
      check_eq("ovr_valid", valid_a, 1'b1);
      check_eq("ovr_data", data_a, 8'h11);
      check_eq("ovr_flags", {pe_a, fe_a, bd_a, oe_a}, 4'b0001);
      tick();
      ready_a = 1'b1;
      tick();
      ready_a = 1'b0;
      @(negedge baud_clk);
      check_eq("ovr_acc_valid", valid_a, 1'b0);
      check_eq("ovr_acc_flag", oe_a, 1'b0);
      check_eq("ovr_acc_hold_data", data_a, 8'h11);
      pop_rec(0, r);
      check_eq("ovr_acc_word", {r.data, r.flags}, {9'h011, 4'b0001});
      check_eq("ovr_acc_count", q_a.size(), 0);

      // Break: line low for 30 bit times
      tick();
      ready_a = 1'b1;
      rx_a    = 1'b0;
      repeat (30 * OS) tick();
      @(negedge baud_clk);
      check_eq("brk_active_while_low", act_a, 1'b1);
      check_eq("brk_count_low", q_a.size(), 1);
      tick();
      rx_a = 1'b1;
      repeat (2 * OS) tick();
      @(negedge baud_clk);
      check_eq("brk_count_high", q_a.size(), 1);
      check_eq("brk_idle", act_a, 1'b0);
      pop_rec(0, r);
      check_eq("brk_data", r.data, 9'h000);
      check_eq("brk_flags", r.flags, 4'b0110);
      send_bits(0, {6'h3F, 1'b1, 8'h96, 1'b0}, 10);
      rx_a = 1'b1;
      repeat (2 * OS) tick();
      @(negedge baud_clk);
      pop_rec(0, r);
      check_eq("brk_recover_word", {r.data, r.flags}, {9'h096, 4'b0000});

      // 7O2: 0x5A (even weight, odd parity bit 1), second stop bit low
      send_bits(2, {5'h1F, 1'b0, 1'b1, 1'b1, 7'h5A, 1'b0}, 11);
      rx_c = 1'b1;
      repeat (2 * OS) tick();
      @(negedge baud_clk);
      check_eq("c_stop_valid", valid_c, 1'b1);
      check_eq("c_stop_data", data_c, 7'h5A);
      check_eq("c_stop_flags", {pe_c, fe_c, bd_c, oe_c}, 4'b0100);
      check_eq("c_stop_idle", act_c, 1'b0);

      // Partial frame then reset
      tick();
      send_bits(2, 16'h0002, 4);
      rx_c = 1'b1;
      @(negedge baud_clk);
      check_eq("c_mid_active", act_c, 1'b1);
      tick();
      reset = 1'b1;
      @(negedge baud_clk);
      check_eq("c_rst_data", data_c, 7'h00);
      check_eq("c_rst_flags", {valid_c, pe_c, fe_c, bd_c, oe_c, act_c}, 6'b0);
      tick();
      reset   = 1'b0;
      ready_c = 1'b1;
      repeat (OS) tick();
      send_bits(2, {5'h1F, 1'b1, 1'b1, 1'b1, 7'h3C, 1'b0}, 11);
      rx_c = 1'b1;
      repeat (2 * OS) tick();
      @(negedge baud_clk);
      check_eq("c_clean_count", q_c.size(), 1);
      pop_rec(2, r);
      check_eq("c_clean_word", {r.data, r.flags}, {9'h03C, 4'b0000});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Parametrised UART receive front end, successor to the fixed 11-bit serial-to-parallel receiver. Clocked by the oversampling baud clock. Recovers frames of configurable data width, parity mode and stop-bit count, using majority-vote sampling and false-start rejection. Presents each payload with per-word error flags on a valid/ready holding register, so no separate deframe stage is needed downstream.

Parameters:
DATA_BITS, 8, payload bits per frame, legal 5..9, sent LSB first
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked, 1 or 2
OVERSAMPLE, 16, baud_clk cycles per bit, even, >= 8

Ports:
baud_clk  in  1  oversampling clock; all logic on its rising edge
reset  in  1  asynchronous, active-high reset
rx_in  in  1  raw serial line, idle high, asynchronous to baud_clk
rx_data  out  DATA_BITS  received payload, valid while rx_valid=1
rx_valid  out  1  holding register contains an unconsumed word
rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready
parity_err  out  1  parity mismatch on held word (0 when PARITY_MODE=0)
frame_err  out  1  a stop bit of the held word was sampled 0
break_det  out  1  held word is a break: all data, parity and stop samples were 0
overrun_err  out  1  at least one later frame was dropped while this word was held
rx_active  out  1  FSM is not in IDLE

Behaviour:
- Reset: one asynchronous reset event, active-high, drives all of the following. Synchroniser flops go to 1. FSM goes to IDLE and counters go to 0. rx_data=0, rx_valid=0, parity_err=0, frame_err=0, break_det=0, overrun_err=0, rx_active=0. A reset mid-frame discards the partial frame and any held word.
- rx_in passes through a 2-flop synchroniser (rxs), giving 2 cycles of latency. All sampling below uses rxs.
- Bit timer: cnt runs 0..OVERSAMPLE-1 and is cleared on every state entry. MID = OVERSAMPLE/2. Samples are taken at cnt = MID-1, MID and MID+1. The bit value is the 2-of-3 majority, decided at cnt = MID+1.
- States: IDLE, START, DATA, PARITY, STOP, BRKWAIT.
- IDLE: rxs=0 -> START, cnt=0.
- START: majority=1 at MID+1 -> false start, return to IDLE and do not report it. Majority=0 -> stay until cnt=OVERSAMPLE-1, then go to DATA.
- DATA: shift each decided bit into the MSB of the shift register (LSB first on the line). After DATA_BITS bits, go to PARITY if PARITY_MODE!=0, else to STOP. Each transition happens at cnt=OVERSAMPLE-1.
- PARITY: the computed parity is the XOR of the data bits. Even mode: error if received bit != computed parity. Odd mode: error if received bit == computed parity.
- STOP: evaluate STOP_BITS bits. Any 0 sets frame_err. The frame completes at MID+1 of the last stop bit, not at the end of the bit period, so the next start edge is caught early. On completion go to IDLE; if rxs=0 and the frame is a break, go to BRKWAIT instead.
- BRKWAIT: stay until rxs=1, then go to IDLE.
- Completion, held register empty or being accepted in the same cycle: the next cycle shows rx_valid=1 with rx_data and the error flags loaded. overrun_err=0.
- Completion while rx_valid && !rx_ready: the new frame is dropped. rx_data and the other flags are unchanged; overrun_err is set to 1.
- Acceptance with no completion in the same cycle: the next cycle shows rx_valid=0 and all flags=0. rx_data holds its last value.
- rx_valid must not drop without acceptance.
- rx_active=1 in every state except IDLE, including BRKWAIT.
- Latency: a frame is reported 2 + (1+DATA_BITS+P+STOP_BITS-1)*OVERSAMPLE + MID+2 cycles after the falling edge of rx_in, where P=1 if parity is enabled. This is for an edge aligned to baud_clk.
- Back-to-back frames with no idle gap are received with no loss.

Test Plan:
- 8N1, OVERSAMPLE=16, send 0x55 then 0xA3 back-to-back with rx_ready=1 -> two rx_valid pulses, rx_data=0x55 then 0xA3, all error flags 0.
- PARITY_MODE=1, send 0x07 with parity bit 0 (wrong) -> rx_data=0x07, parity_err=1. Resend with parity bit 1 -> parity_err=0.
- rx_in low for 4 cycles then high -> returns to IDLE, rx_valid never asserts, rx_active pulses high.
- rx_ready=0, send 0x11, 0x22, 0x33 -> rx_data stays 0x11 with overrun_err=1. Then rx_ready=1 for one cycle -> rx_valid=0, overrun_err=0.
- Hold rx_in low for 30 bit times -> one word with rx_data=0x00, frame_err=1, break_det=1. No further words arrive until the line is high and a new start bit is sent.
- DATA_BITS=7, PARITY_MODE=2, STOP_BITS=2: send 0x5A with the second stop bit 0 -> frame_err=1. Assert reset mid-frame on the next frame -> all outputs 0, and the next clean frame 0x3C is received correctly.
